seq_comparator: RTL
===================

SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, bits compared per cycle; WIDTH % CHUNK != 0 SHALL raise an elaboration error; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 greater  output  1  A > B.
REQ-013 less  output  1  A < B.
REQ-014 equal  output  1  A == B.

Function
REQ-015 FSM states SHALL be IDLE, COMPARE, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE with rst low.
REQ-017 Acceptance SHALL occur on a rising edge with in_valid & in_ready; a, b, signed_mode latched; chunk index set to NCHUNK-1; state -> COMPARE; greater/less/equal cleared.
REQ-018 Inputs a, b, signed_mode SHALL be ignored outside acceptance edges.
REQ-019 In COMPARE, each cycle SHALL compare one CHUNK slice, MSB slice first, index decrementing by 1.
REQ-020 The top slice SHALL be compared signed when signed_mode=1; all lower slices unsigned.
REQ-021 Slice mismatch SHALL set greater or less accordingly and move to DONE (early termination).
REQ-022 Slice match at index 0 SHALL set equal and move to DONE.
REQ-023 Latency from acceptance edge to out_valid high SHALL be m cycles, m = slices examined, 1 <= m <= NCHUNK.
REQ-024 In DONE, out_valid SHALL be 1 and exactly one of greater/less/equal SHALL be 1.
REQ-025 Result outputs SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-026 A rising edge with out_valid & out_ready SHALL return to IDLE; outputs hold last result until the next acceptance.
REQ-027 No new operand SHALL be accepted on the same edge a result is consumed (in_ready=0 in DONE).
REQ-028 out_valid SHALL be 0 in IDLE and COMPARE.

Reset
REQ-029 rst assertion SHALL immediately force IDLE, out_valid=0, greater=less=equal=0, chunk index 0, operand registers 0.
REQ-030 rst in COMPARE or DONE SHALL discard the pending operation without producing a result.
REQ-031 in_ready SHALL be 0 while rst is high and 1 on the first cycle after release.

Structure
REQ-032 Package cmp_pkg SHALL hold the state encoding typedef and the NCHUNK derivation helper.
REQ-033 One sub-module chunk_cmp (combinational CHUNK-bit compare with signed flag, outputs gt/lt) SHALL be instantiated once and muxed by chunk index.

Verification (WIDTH=32, CHUNK=8)
REQ-034 a=F0000000, b=0F000000, signed_mode=0 -> greater=1, out_valid 1 cycle after acceptance.
REQ-035 a=b=FFFFFFFF -> equal=1, out_valid 4 cycles after acceptance.
REQ-036 a=80000000, b=00000001: signed_mode=1 -> less=1; signed_mode=0 -> greater=1; a=12345678, b=12345679 -> less=1 after 4 cycles.
REQ-037 out_ready held 0 for 3 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-038 rst pulsed during COMPARE (slice 2) -> out_valid=0, flags 0 immediately, in_ready=1 first cycle after release, no result emitted.
REQ-039 1000 random pairs, random signed_mode, random out_ready stalls -> every result matches behavioural model, latency equals slices examined.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential chunked magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational CHUNK-bit magnitude compare; is_signed treats x/y as two's-complement.
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             is_signed,
  output logic             gt,
  output logic             lt
);

  logic [CHUNK-1:0] x_b;
  logic [CHUNK-1:0] y_b;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    x_b            = x;
    y_b            = y;
    x_b[CHUNK-1]   = x[CHUNK-1] ^ is_signed;
    y_b[CHUNK-1]   = y[CHUNK-1] ^ is_signed;
  end

  assign gt = (x_b > y_b);
  assign lt = (x_b < y_b);

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle comparator: walks operand slices MSB-first, stopping at the first mismatch.
module seq_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             greater,
  output logic             less,
  output logic             equal
);
  import cmp_pkg::*;

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((CHUNK <= 0) || (WIDTH % CHUNK != 0)) begin : g_bad_param
      $error("seq_comparator: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic             top_slice;
  logic             gt;
  logic             lt;
  logic             accept;
  logic             last_slice;

  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign top_slice  = (idx == IW'(NCHUNK - 1));
  assign last_slice = (idx == '0);
  assign slice_a    = a_q[idx*CHUNK +: CHUNK];
  assign slice_b    = b_q[idx*CHUNK +: CHUNK];

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .x         (slice_a),
    .y         (slice_b),
    .is_signed (sm_q && top_slice),
    .gt        (gt),
    .lt        (lt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = COMPARE;
      COMPARE: if (gt || lt || last_slice) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are cleared only on acceptance so the last result stays visible in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      idx     <= '0;
      greater <= 1'b0;
      less    <= 1'b0;
      equal   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sm_q    <= signed_mode;
      idx     <= IW'(NCHUNK - 1);
      greater <= 1'b0;
      less    <= 1'b0;
      equal   <= 1'b0;
    end else if (state == COMPARE) begin
      if (gt)              greater <= 1'b1;
      else if (lt)         less    <= 1'b1;
      else if (last_slice) equal   <= 1'b1;
      else                 idx     <= idx - 1'b1;
    end
  end

endmodule
